// File: rtl/stage_nhead.sv
// Multi-head token accumulator: each head sums token*weight+bias over SEQ_LEN
// tokens, then the per-head results are drained one head per handshake.
module stage_nhead #(
  parameter int unsigned NUM_HEADS = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned SEQ_LEN = 4,
  parameter logic [NUM_HEADS*WEIGHT_W-1:0] HEAD_WEIGHTS = {8'sd4, 8'sd3, 8'sd2, 8'sd1},
  parameter int unsigned SHIFT = 0,
  localparam int unsigned HEAD_W = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic signed [DATA_W-1:0]      i_stage,
  input  logic [NUM_HEADS*DATA_W-1:0]   bias,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic signed [DATA_W-1:0]      o_stage,
  output logic [HEAD_W-1:0]             o_head,
  output logic                          end_s
);

  localparam int unsigned CNT_W = $clog2(SEQ_LEN + 1);
  localparam int unsigned ACC_W = DATA_W + WEIGHT_W + $clog2(SEQ_LEN) + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                    state;
  state_t                    state_next;
  logic signed [ACC_W-1:0]   acc     [NUM_HEADS];
  logic signed [ACC_W-1:0]   acc_sum [NUM_HEADS];
  logic signed [WEIGHT_W-1:0] weight [NUM_HEADS];
  logic signed [DATA_W-1:0]  bias_h  [NUM_HEADS];
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_inc;
  logic                      accept;
  logic                      handshake;
  logic                      last_token;
  logic                      last_head;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  sat_val;

  // i_ready is gated by rst so it reads 0 during reset even with en high
  assign i_ready    = en && !rst && (state != DRAIN);
  assign accept     = i_valid && i_ready;
  assign o_valid    = en && (state == DRAIN);
  assign handshake  = o_valid && o_ready;
  assign count_inc  = count + CNT_W'(1);
  assign last_token = (count_inc == CNT_W'(SEQ_LEN));
  assign last_head  = (o_head == HEAD_W'(NUM_HEADS - 1));

  always_comb begin
    for (int unsigned h = 0; h < NUM_HEADS; h++) begin
      weight[h]  = $signed(HEAD_WEIGHTS[h*WEIGHT_W +: WEIGHT_W]);
      bias_h[h]  = $signed(bias[h*DATA_W +: DATA_W]);
      acc_sum[h] = acc[h] + ACC_W'(i_stage) * ACC_W'(weight[h]) + ACC_W'(bias_h[h]);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = last_token ? DRAIN : ACCUM;
      ACCUM:   if (accept && last_token) state_next = DRAIN;
      DRAIN:   if (handshake && last_head) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shifted = acc[o_head] >>> SHIFT;
    sat_val = shifted[DATA_W-1:0];
    if (shifted > $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}}))
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}}))
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    o_stage = (state == DRAIN) ? sat_val : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      o_head <= '0;
      end_s  <= 1'b0;
      for (int unsigned h = 0; h < NUM_HEADS; h++) acc[h] <= '0;
    end else begin
      state <= state_next;
      end_s <= handshake && last_head;
      if (accept) begin
        count <= count_inc;
        for (int unsigned h = 0; h < NUM_HEADS; h++) acc[h] <= acc_sum[h];
      end else if (handshake) begin
        if (last_head) begin
          count  <= '0;
          o_head <= '0;
          for (int unsigned h = 0; h < NUM_HEADS; h++) acc[h] <= '0;
        end else begin
          o_head <= o_head + HEAD_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/stage_nhead.md
STAGE_NHEAD -- requirements
Module: stage_nhead

Interface
REQ-001 Parameter NUM_HEADS, default 4: number of parallel attention heads, range 1..16.
REQ-002 Parameter DATA_W, default 16: signed width of input token, bias and output.
REQ-003 Parameter WEIGHT_W, default 8: signed width of each head weight.
REQ-004 Parameter SEQ_LEN, default 4: number of tokens accumulated per pass, at least 1.
REQ-005 Parameter HEAD_WEIGHTS, default {8'sd4,8'sd3,8'sd2,8'sd1}: packed NUM_HEADS*WEIGHT_W bits, head h in slice h.
REQ-006 Parameter SHIFT, default 0: arithmetic right shift applied before output saturation.
REQ-007 Port clk, input, 1: single clock, rising edge.
REQ-008 Port rst, input, 1: asynchronous, active-high reset.
REQ-009 Port en, input, 1: stage enable; low freezes all state.
REQ-010 Port i_valid, input, 1: input token valid.
REQ-011 Port i_ready, output, 1: stage accepts a token.
REQ-012 Port i_stage, input, DATA_W: signed input token.
REQ-013 Port bias, input, NUM_HEADS*DATA_W: signed per-head bias, sampled with each accepted token.
REQ-014 Port o_valid, output, 1: result valid.
REQ-015 Port o_ready, input, 1: downstream accepts result.
REQ-016 Port o_stage, output, DATA_W: signed head result.
REQ-017 Port o_head, output, clog2(NUM_HEADS) bits (min 1): index of head on o_stage.
REQ-018 Port end_s, output, 1: one-cycle pulse at pass completion.

Function
REQ-019 FSM states are IDLE, ACCUM and DRAIN; a token is accepted when i_valid and i_ready are both high.
REQ-020 i_ready is high only when en is high and the state is IDLE or ACCUM.
REQ-021 On each accepted token, every head h updates acc[h] += i_stage*w[h] + bias[h] in full signed precision.
- Accumulator width is DATA_W+WEIGHT_W+clog2(SEQ_LEN)+2 bits.
- No accumulator overflow is possible at this width.
REQ-022 IDLE moves to ACCUM on the first accepted token with the token count set to 1; when SEQ_LEN=1, IDLE moves directly to DRAIN.
REQ-023 ACCUM moves to DRAIN on the accept that makes the token count equal SEQ_LEN.
REQ-024 o_valid is high only when the state is DRAIN and en is high.
- First o_valid occurs the cycle after the final accept.
REQ-025 In DRAIN, o_stage is sat(acc[o_head] >>> SHIFT), saturated to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-026 In DRAIN, o_head starts at 0 and advances by one on each o_valid and o_ready handshake.
REQ-027 While o_ready is low, o_stage and o_head hold their values.
REQ-028 On the handshake for head NUM_HEADS-1:
- The state returns to IDLE.
- All accumulators, the token count and o_head clear.
- end_s pulses high for exactly the next cycle.
REQ-029 While en is low:
- No token is accepted.
- No handshake completes.
- Counters, accumulators and state hold.
- end_s does not assert.
REQ-030 No new token is accepted in DRAIN; the input stream back-pressures until the drain completes.

Reset
REQ-031 While rst is high, asynchronously:
- The state is IDLE.
- Accumulators, token count and o_head are 0.
- i_ready, o_valid, end_s and o_stage are 0.
REQ-032 Reset asserted mid-ACCUM or mid-DRAIN discards the pass; no end_s pulse is generated.

Verification
REQ-033 Defaults, en=1, o_ready=1; tokens 1,2,3,4 with all biases 4,5,6,7 on consecutive cycles -> o_stage 32,42,52,62 with o_head 0..3 on 4 consecutive cycles, then end_s high one cycle.
REQ-034 Defaults, four tokens of 32767 with bias 0 -> every head outputs 32767; four tokens of -32768 with bias 0 -> every head outputs -32768.
REQ-035 As REQ-033, with o_ready low for 3 cycles at head 1 -> o_stage stays 42 and o_head stays 1 during the stall; the sequence then completes, and a fifth token presented during DRAIN is not accepted until IDLE.
REQ-036 As REQ-033, with en low for 5 cycles after token 2 -> i_ready is 0 and tokens presented are ignored; results are still 32,42,52,62 after resuming with tokens 3,4.
REQ-037 rst pulsed during DRAIN after head 1 -> all outputs 0 asynchronously with no end_s; a fresh REQ-033 pass then gives the same results.
REQ-038 SEQ_LEN=1, SHIFT=1, token 10, bias 0 -> outputs 5,10,15,20, with DRAIN entered directly from IDLE.
